// File: rtl/ble_packet_deframer.sv
// BLE bit-stream deframer: access-address search with Hamming tolerance, optional
// dewhitening, header/length/payload byte extraction and CRC24 check.
module ble_packet_deframer #(
    parameter int          MAX_ERR  = 1,
    parameter int          MAX_LEN  = 37,
    parameter logic [23:0] CRC_INIT = 24'h555555
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        update,
    input  logic        data_in,
    input  logic [31:0] access_addr,
    input  logic        dewhiten_en,
    input  logic [5:0]  chan_idx,
    output logic        busy,
    output logic        pkt_start,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    output logic [7:0]  pkt_len,
    output logic        pkt_done,
    output logic        crc_ok,
    output logic        len_err
);

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, CRC} state_t;

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [5:0] MAX_ERR_C = 6'(MAX_ERR);

    state_t      state, state_n;
    logic        update_d;
    logic [31:0] aa_sr, aa_n, aa_shift;
    logic [6:0]  w, w_n, w_step;
    logic [23:0] crc, crc_n, crc_step, crc_rx, crc_rx_n;
    logic [7:0]  shift_sr, shift_n, byte_full;
    logic [2:0]  bit_cnt, bit_cnt_n;
    logic [7:0]  byte_cnt, byte_cnt_n;
    logic        hdr_idx, hdr_idx_n;
    logic [4:0]  crc_cnt, crc_cnt_n;
    logic        busy_n, pkt_start_n, byte_valid_n, pkt_done_n, crc_ok_n, len_err_n;
    logic [7:0]  byte_out_n, pkt_len_n;
    logic        take, b, aa_hit;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) c = c + {5'b0, v[i]};
        return c;
    endfunction

    assign take      = update & ~update_d;
    assign b         = data_in ^ (dewhiten_en & w[6]);
    assign aa_shift  = {data_in, aa_sr[31:1]};
    assign aa_hit    = popcount32(aa_shift ^ access_addr) <= MAX_ERR_C;
    assign byte_full = {b, shift_sr[7:1]};
    assign w_step    = {w[5], w[4], w[3] ^ w[6], w[2], w[1], w[0], w[6]};
    assign crc_step  = {crc[22:0], 1'b0} ^ ((crc[23] ^ b) ? 24'h00065B : 24'h000000);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n      = state;
        aa_n         = aa_sr;
        w_n          = w;
        crc_n        = crc;
        crc_rx_n     = crc_rx;
        shift_n      = shift_sr;
        bit_cnt_n    = bit_cnt;
        byte_cnt_n   = byte_cnt;
        hdr_idx_n    = hdr_idx;
        crc_cnt_n    = crc_cnt;
        busy_n       = busy;
        byte_out_n   = byte_out;
        pkt_len_n    = pkt_len;
        crc_ok_n     = crc_ok;
        pkt_start_n  = 1'b0;
        byte_valid_n = 1'b0;
        pkt_done_n   = 1'b0;
        len_err_n    = 1'b0;

        // Disable wins over any bit arriving in the same cycle and aborts silently
        if (!en) begin
            state_n = IDLE;
            aa_n    = '0;
            busy_n  = 1'b0;
        end else if (take) begin
            case (state)
                IDLE: begin
                    aa_n = aa_shift;
                    if (aa_hit) begin
                        state_n     = HEADER;
                        aa_n        = '0;
                        pkt_start_n = 1'b1;
                        busy_n      = 1'b1;
                        crc_ok_n    = 1'b0;
                        w_n         = {chan_idx[0], chan_idx[1], chan_idx[2],
                                       chan_idx[3], chan_idx[4], chan_idx[5], 1'b1};
                        crc_n       = CRC_INIT;
                        bit_cnt_n   = '0;
                        byte_cnt_n  = '0;
                        hdr_idx_n   = 1'b0;
                        crc_cnt_n   = '0;
                    end
                end
                HEADER, PAYLOAD: begin
                    w_n       = w_step;
                    crc_n     = crc_step;
                    shift_n   = byte_full;
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        byte_out_n   = byte_full;
                        byte_valid_n = 1'b1;
                        if (state == HEADER) begin
                            if (!hdr_idx) begin
                                hdr_idx_n = 1'b1;
                            end else begin
                                pkt_len_n = byte_full;
                                // Oversized length: report and drop without waiting for a CRC
                                if (byte_full > MAX_LEN_B) begin
                                    len_err_n  = 1'b1;
                                    pkt_done_n = 1'b1;
                                    crc_ok_n   = 1'b0;
                                    busy_n     = 1'b0;
                                    aa_n       = '0;
                                    state_n    = IDLE;
                                end else if (byte_full == 8'd0) begin
                                    state_n = CRC;
                                end else begin
                                    byte_cnt_n = '0;
                                    state_n    = PAYLOAD;
                                end
                            end
                        end else begin
                            byte_cnt_n = byte_cnt + 8'd1;
                            if (byte_cnt + 8'd1 == pkt_len) state_n = CRC;
                        end
                    end
                end
                CRC: begin
                    w_n       = w_step;
                    crc_rx_n  = {crc_rx[22:0], b};
                    crc_cnt_n = crc_cnt + 5'd1;
                    if (crc_cnt == 5'd23) begin
                        crc_ok_n   = ({crc_rx[22:0], b} == crc);
                        pkt_done_n = 1'b1;
                        busy_n     = 1'b0;
                        aa_n       = '0;
                        state_n    = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            update_d   <= 1'b0;
            aa_sr      <= '0;
            w          <= '0;
            crc        <= '0;
            crc_rx     <= '0;
            shift_sr   <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            hdr_idx    <= 1'b0;
            crc_cnt    <= '0;
            busy       <= 1'b0;
            pkt_start  <= 1'b0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
            pkt_len    <= '0;
            pkt_done   <= 1'b0;
            crc_ok     <= 1'b0;
            len_err    <= 1'b0;
        end else begin
            update_d   <= update;
            aa_sr      <= aa_n;
            w          <= w_n;
            crc        <= crc_n;
            crc_rx     <= crc_rx_n;
            shift_sr   <= shift_n;
            bit_cnt    <= bit_cnt_n;
            byte_cnt   <= byte_cnt_n;
            hdr_idx    <= hdr_idx_n;
            crc_cnt    <= crc_cnt_n;
            busy       <= busy_n;
            pkt_start  <= pkt_start_n;
            byte_out   <= byte_out_n;
            byte_valid <= byte_valid_n;
            pkt_len    <= pkt_len_n;
            pkt_done   <= pkt_done_n;
            crc_ok     <= crc_ok_n;
            len_err    <= len_err_n;
        end
    end

endmodule

// File: tb/tb_ble_packet_deframer.sv
// Scoreboard bench for ble_packet_deframer: a bit-level packet framer feeds the DUT
// and queues expected events; a monitor pops and compares them as the DUT emits them.
`timescale 1ns/1ps
module tb_ble_packet_deframer;

    localparam int          MAX_ERR  = 1;
    localparam int          MAX_LEN  = 37;
    localparam logic [23:0] CRC_INIT = 24'h555555;
    localparam logic [31:0] AA       = 32'h8E89BED6;

    typedef enum int {EV_START, EV_BYTE, EV_DONE} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [7:0] val;
        logic       crc_ok;
        logic       len_err;
        logic [7:0] len;
    } exp_t;
    typedef struct {
        int   at;
        exp_t e;
    } pend_t;

    logic        clk = 1'b0, rst = 1'b0, en = 1'b0, update = 1'b0, data_in = 1'b0;
    logic        dewhiten_en = 1'b0;
    logic [31:0] access_addr = AA;
    logic [5:0]  chan_idx = 6'd0;
    logic        busy, pkt_start, byte_valid, pkt_done, crc_ok, len_err;
    logic [7:0]  byte_out, pkt_len;

    exp_t  exp_q[$];
    pend_t pend_q[$];
    logic  tx_bits[$];
    logic  start_after_take;
    logic  pkt_expect_match;
    exp_t  mon_e;
    int    checks = 0;
    int    errors = 0;
    logic [7:0] pay [0:2] = '{8'hAA, 8'h55, 8'h0F};

    ble_packet_deframer #(.MAX_ERR(MAX_ERR), .MAX_LEN(MAX_LEN), .CRC_INIT(CRC_INIT)) dut (
        .clk(clk), .rst(rst), .en(en), .update(update), .data_in(data_in),
        .access_addr(access_addr), .dewhiten_en(dewhiten_en), .chan_idx(chan_idx),
        .busy(busy), .pkt_start(pkt_start), .byte_out(byte_out), .byte_valid(byte_valid),
        .pkt_len(pkt_len), .pkt_done(pkt_done), .crc_ok(crc_ok), .len_err(len_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic report_unexpected(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_%s: got pulse, expected none", name);
    endtask

    // Transmit side: builds the on-air bit stream and schedules expected DUT events per bit
    task automatic build_packet(input logic [31:0] aa_tx, input logic aa_match,
                                input logic [7:0] hdr, input logic [7:0] len,
                                input logic wht, input logic [5:0] ch,
                                input int flip_byte, input int flip_bit);
        logic [6:0]  w;
        logic [23:0] crc;
        logic [7:0]  byte_v, obs;
        logic        bv, fb, tx;
        bit          abort;
        int          nbytes;
        tx_bits.delete();
        pend_q.delete();
        pkt_expect_match = aa_match;
        for (int i = 0; i < 32; i++) tx_bits.push_back(aa_tx[i]);
        if (aa_match) pend_q.push_back('{at: 31, e: '{kind: EV_START, val: 8'h00, crc_ok: 1'b0, len_err: 1'b0, len: 8'h00}});
        w      = {ch[0], ch[1], ch[2], ch[3], ch[4], ch[5], 1'b1};
        crc    = CRC_INIT;
        abort  = int'(len) > MAX_LEN;
        nbytes = abort ? 2 : 2 + int'(len);
        for (int k = 0; k < nbytes; k++) begin
            byte_v = (k == 0) ? hdr : (k == 1) ? len : pay[k-2];
            obs    = byte_v;
            if (k == flip_byte) obs[flip_bit] = ~obs[flip_bit];
            for (int j = 0; j < 8; j++) begin
                bv  = byte_v[j];
                fb  = crc[23] ^ bv;
                crc = {crc[22:0], 1'b0} ^ (fb ? 24'h00065B : 24'h000000);
                tx  = bv ^ (wht & w[6]) ^ ((k == flip_byte) && (j == flip_bit));
                w   = {w[5], w[4], w[3] ^ w[6], w[2], w[1], w[0], w[6]};
                tx_bits.push_back(tx);
            end
            if (aa_match) begin
                pend_q.push_back('{at: tx_bits.size() - 1, e: '{kind: EV_BYTE, val: obs, crc_ok: 1'b0, len_err: 1'b0, len: 8'h00}});
                if (abort && k == 1)
                    pend_q.push_back('{at: tx_bits.size() - 1, e: '{kind: EV_DONE, val: 8'h00, crc_ok: 1'b0, len_err: 1'b1, len: len}});
            end
        end
        if (!abort) begin
            for (int i = 23; i >= 0; i--) begin
                tx = crc[i] ^ (wht & w[6]);
                w  = {w[5], w[4], w[3] ^ w[6], w[2], w[1], w[0], w[6]};
                tx_bits.push_back(tx);
            end
            if (aa_match)
                pend_q.push_back('{at: tx_bits.size() - 1, e: '{kind: EV_DONE, val: 8'h00, crc_ok: (flip_byte < 0), len_err: 1'b0, len: len}});
        end
    endtask

    // One bit: update rises at a falling clock edge and stays high for 'hold' cycles
    task automatic send_bit(input logic bv, input int hold);
        data_in = bv;
        update  = 1'b1;
        @(negedge clk);
        start_after_take = pkt_start;
        repeat (hold - 1) @(negedge clk);
        update = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic applyStimulus(input int nbits, input int long_idx);
        int n;
        n = (nbits < 0 || nbits > tx_bits.size()) ? tx_bits.size() : nbits;
        for (int i = 0; i < n; i++) begin
            while (pend_q.size() != 0 && pend_q[0].at == i) exp_q.push_back(pend_q.pop_front().e);
            send_bit(tx_bits[i], (i == long_idx) ? 20 : 2);
            if (i == 31 && pkt_expect_match) checkOutput("pkt_start_timing", 32'(start_after_take), 32'd1);
        end
    endtask

    task automatic clear_search();
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
    endtask

    // Monitor: every output event must match the head of the expectation queue
    always @(negedge clk) begin
        if (pkt_start) begin
            if (exp_q.size() == 0) report_unexpected("pkt_start");
            else begin
                mon_e = exp_q.pop_front();
                checkOutput("start_kind", 32'(mon_e.kind), 32'(EV_START));
                checkOutput("busy_at_start", 32'(busy), 32'd1);
            end
        end
        if (byte_valid) begin
            if (exp_q.size() == 0) report_unexpected("byte_valid");
            else begin
                mon_e = exp_q.pop_front();
                checkOutput("byte_kind", 32'(mon_e.kind), 32'(EV_BYTE));
                checkOutput("byte_out", 32'(byte_out), 32'(mon_e.val));
            end
        end
        if (pkt_done) begin
            if (exp_q.size() == 0) report_unexpected("pkt_done");
            else begin
                mon_e = exp_q.pop_front();
                checkOutput("done_kind", 32'(mon_e.kind), 32'(EV_DONE));
                checkOutput("crc_ok", 32'(crc_ok), 32'(mon_e.crc_ok));
                checkOutput("len_err", 32'(len_err), 32'(mon_e.len_err));
                checkOutput("pkt_len", 32'(pkt_len), 32'(mon_e.len));
            end
        end
        if (len_err && !pkt_done) report_unexpected("len_err");
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            update  = ~update;
            data_in = ~data_in;
            checkOutput("reset_outputs", 32'({busy, pkt_start, byte_valid, pkt_done, crc_ok, len_err, byte_out, pkt_len}), 32'd0);
        end
        update = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 100; i++) send_bit(1'($urandom_range(0, 1)), 2);
        checkOutput("random_no_busy", 32'(busy), 32'd0);

        $display("[TB] good packet");
        clear_search();
        build_packet(AA, 1'b1, 8'h02, 8'h03, 1'b0, 6'd0, -1, 0);
        applyStimulus(-1, -1);
        checkOutput("good_busy_after", 32'(busy), 32'd0);
        checkOutput("good_crc_ok_held", 32'(crc_ok), 32'd1);
        checkOutput("good_drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] access address tolerance");
        clear_search();
        build_packet(AA ^ 32'h0000_0080, 1'b1, 8'h02, 8'h03, 1'b0, 6'd0, -1, 0);
        applyStimulus(-1, -1);
        checkOutput("aa1_drain", 32'(exp_q.size()), 32'd0);
        clear_search();
        build_packet(AA ^ 32'h0010_0008, 1'b0, 8'h02, 8'h03, 1'b0, 6'd0, -1, 0);
        applyStimulus(-1, -1);
        checkOutput("aa2_no_busy", 32'(busy), 32'd0);
        checkOutput("aa2_drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] crc error");
        clear_search();
        build_packet(AA, 1'b1, 8'h02, 8'h03, 1'b0, 6'd0, 2, 5);
        applyStimulus(-1, -1);
        checkOutput("crcerr_crc_ok", 32'(crc_ok), 32'd0);
        checkOutput("crcerr_drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] length abort");
        clear_search();
        build_packet(AA, 1'b1, 8'h02, 8'h40, 1'b0, 6'd0, -1, 0);
        applyStimulus(-1, -1);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_drain", 32'(exp_q.size()), 32'd0);
        build_packet(AA, 1'b1, 8'h02, 8'h03, 1'b0, 6'd0, -1, 0);
        applyStimulus(-1, -1);
        checkOutput("after_abort_crc_ok", 32'(crc_ok), 32'd1);
        checkOutput("after_abort_drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] long update strobe");
        clear_search();
        build_packet(AA, 1'b1, 8'h02, 8'h03, 1'b0, 6'd0, -1, 0);
        applyStimulus(-1, 32);
        checkOutput("long_strobe_drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] reset mid-payload");
        clear_search();
        build_packet(AA, 1'b1, 8'h02, 8'h03, 1'b0, 6'd0, -1, 0);
        applyStimulus(56, -1);
        checkOutput("mid_busy_before_reset", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("mid_reset_outputs", 32'({busy, pkt_start, byte_valid, pkt_done, crc_ok, len_err, byte_out, pkt_len}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_reset_drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] enable drop mid-packet");
        clear_search();
        build_packet(AA, 1'b1, 8'h02, 8'h03, 1'b0, 6'd0, -1, 0);
        applyStimulus(60, -1);
        en = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("en_drop_busy", 32'(busy), 32'd0);
        en = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("en_drop_drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] dewhitened packet");
        dewhiten_en = 1'b1;
        chan_idx    = 6'd37;
        clear_search();
        build_packet(AA, 1'b1, 8'h02, 8'h03, 1'b1, 6'd37, -1, 0);
        applyStimulus(-1, -1);
        checkOutput("dewhiten_crc_ok", 32'(crc_ok), 32'd1);
        checkOutput("dewhiten_drain", 32'(exp_q.size()), 32'd0);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
